// File: rtl/hyperbus_pkg.sv
// Shared types and default sizing for the HyperBus transaction arbiter.
package hyperbus_pkg;

  localparam int DEF_NR_REQ      = 2;
  localparam int DEF_BURST_WIDTH = 12;
  localparam int DEF_NR_CS       = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DATA  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arb_sel.sv
// Round-robin selector: scans requesters starting after last_idx_i and
// returns the first active one as a one-hot grant and as an index.
module rr_arb_sel import hyperbus_pkg::*; #(
  parameter int NR_REQ = DEF_NR_REQ,
  parameter int IDX_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
  input  logic [NR_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]  last_idx_i,
  output logic [NR_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]  idx_o
);

  logic             found;
  int               j;
  logic [IDX_W-1:0] jj;

  // Priority rotates so the requester right after the last winner is looked at first.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    jj      = '0;
    for (int i = 1; i <= NR_REQ; i++) begin
      j  = (int'(last_idx_i) + i) % NR_REQ;
      jj = IDX_W'(j);
      if (!found && req_i[jj]) begin
        found     = 1'b1;
        grant_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end

endmodule

// File: rtl/hyperbus_trans_arbiter.sv
// Arbitrates several HyperBus requesters onto one PHY: one transaction at a
// time, data channels steered to the winner until the burst completes.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no owner; arbitrate as soon as any request is valid
// ST_ISSUE | present registered transaction to the PHY (burst 0: ack only)
// ST_DATA  | steer tx or rx data between winner and PHY, count beats down
// ST_DONE  | one-cycle gap; remember winner for the next round-robin pass
module hyperbus_trans_arbiter import hyperbus_pkg::*; #(
  parameter int NR_REQ      = DEF_NR_REQ,
  parameter int BURST_WIDTH = DEF_BURST_WIDTH,
  parameter int NR_CS       = DEF_NR_CS
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NR_REQ-1:0]                req_trans_valid_i,
  output logic [NR_REQ-1:0]                req_trans_ready_o,
  input  logic [NR_REQ-1:0][31:0]          req_trans_address_i,
  input  logic [NR_REQ-1:0][NR_CS-1:0]     req_trans_cs_i,
  input  logic [NR_REQ-1:0]                req_trans_write_i,
  input  logic [NR_REQ-1:0][BURST_WIDTH-1:0] req_trans_burst_i,
  input  logic [NR_REQ-1:0]                req_tx_valid_i,
  output logic [NR_REQ-1:0]                req_tx_ready_o,
  input  logic [NR_REQ-1:0][15:0]          req_tx_data_i,
  input  logic [NR_REQ-1:0][1:0]           req_tx_strb_i,
  output logic [NR_REQ-1:0]                req_rx_valid_o,
  input  logic [NR_REQ-1:0]                req_rx_ready_i,
  output logic [NR_REQ-1:0][15:0]          req_rx_data_o,
  output logic                             phy_trans_valid_o,
  input  logic                             phy_trans_ready_i,
  output logic [31:0]                      phy_trans_address_o,
  output logic [NR_CS-1:0]                 phy_trans_cs_o,
  output logic                             phy_trans_write_o,
  output logic [BURST_WIDTH-1:0]           phy_trans_burst_o,
  output logic                             phy_tx_valid_o,
  input  logic                             phy_tx_ready_i,
  output logic [15:0]                      phy_tx_data_o,
  output logic [1:0]                       phy_tx_strb_o,
  input  logic                             phy_rx_valid_i,
  output logic                             phy_rx_ready_o,
  input  logic [15:0]                      phy_rx_data_i,
  output logic [NR_REQ-1:0]                grant_o,
  output logic                             busy_o
);

  localparam int IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  arb_state_e             state_q;
  logic [IDX_W-1:0]       win_idx_q, last_idx_q, sel_idx;
  logic [NR_REQ-1:0]      win_oh_q, sel_oh;
  logic [31:0]            addr_q;
  logic [NR_CS-1:0]       cs_q;
  logic                   write_q;
  logic [BURST_WIDTH-1:0] burst_q, beat_cnt_q;
  logic                   burst_zero, trans_hs, data_hs;

  rr_arb_sel #(.NR_REQ(NR_REQ), .IDX_W(IDX_W)) u_sel (
    .req_i      (req_trans_valid_i),
    .last_idx_i (last_idx_q),
    .grant_o    (sel_oh),
    .idx_o      (sel_idx)
  );

  assign burst_zero          = (burst_q == '0);
  assign phy_trans_address_o = addr_q;
  assign phy_trans_cs_o      = cs_q;
  assign phy_trans_write_o   = write_q;
  assign phy_trans_burst_o   = burst_q;
  assign busy_o              = (state_q != ST_IDLE);
  assign grant_o             = busy_o ? win_oh_q : '0;

  // Handshake steering: only the winner sees the PHY, everyone else is held off.
  always_comb begin
    req_trans_ready_o = '0;
    req_tx_ready_o    = '0;
    req_rx_valid_o    = '0;
    req_rx_data_o     = '0;
    phy_trans_valid_o = 1'b0;
    phy_tx_valid_o    = 1'b0;
    phy_tx_data_o     = '0;
    phy_tx_strb_o     = '0;
    phy_rx_ready_o    = 1'b1;
    trans_hs          = 1'b0;
    data_hs           = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        // A zero-length burst never reaches the PHY; it is acked straight away.
        phy_trans_valid_o = !burst_zero;
        trans_hs          = burst_zero || phy_trans_ready_i;
        req_trans_ready_o[win_idx_q] = trans_hs;
      end
      ST_DATA: begin
        if (write_q) begin
          phy_tx_valid_o            = req_tx_valid_i[win_idx_q];
          phy_tx_data_o             = req_tx_data_i[win_idx_q];
          phy_tx_strb_o             = req_tx_strb_i[win_idx_q];
          req_tx_ready_o[win_idx_q] = phy_tx_ready_i;
          data_hs                   = req_tx_valid_i[win_idx_q] && phy_tx_ready_i;
        end else begin
          req_rx_valid_o[win_idx_q] = phy_rx_valid_i;
          req_rx_data_o[win_idx_q]  = phy_rx_data_i;
          phy_rx_ready_o            = req_rx_ready_i[win_idx_q];
          data_hs                   = phy_rx_valid_i && req_rx_ready_i[win_idx_q];
        end
      end
      default: ;
    endcase
  end

  // Sequencer: capture winner, issue, count beats, then one-cycle DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      win_idx_q  <= '0;
      win_oh_q   <= '0;
      last_idx_q <= IDX_W'(NR_REQ - 1);
      addr_q     <= '0;
      cs_q       <= '0;
      write_q    <= 1'b0;
      burst_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req_trans_valid_i) begin
            win_idx_q <= sel_idx;
            win_oh_q  <= sel_oh;
            addr_q    <= req_trans_address_i[sel_idx];
            cs_q      <= req_trans_cs_i[sel_idx];
            write_q   <= req_trans_write_i[sel_idx];
            burst_q   <= req_trans_burst_i[sel_idx];
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (trans_hs) begin
            if (burst_zero) begin
              state_q <= ST_DONE;
            end else begin
              beat_cnt_q <= burst_q;
              state_q    <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (data_hs) begin
            beat_cnt_q <= beat_cnt_q - BURST_WIDTH'(1);
            if (beat_cnt_q == BURST_WIDTH'(1)) state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          last_idx_q <= win_idx_q;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperbus_trans_arbiter.sv
// Scoreboard bench for hyperbus_trans_arbiter: stimulus pushes expected
// transactions/beats, a negedge monitor pops and compares them.
module tb_hyperbus_trans_arbiter;

  localparam int NR = 2;
  localparam int BW = 12;
  localparam int NCS = 2;

  logic                    clk, rst;
  logic [NR-1:0]           req_trans_valid_i, req_trans_ready_o;
  logic [NR-1:0][31:0]     req_trans_address_i;
  logic [NR-1:0][NCS-1:0]  req_trans_cs_i;
  logic [NR-1:0]           req_trans_write_i;
  logic [NR-1:0][BW-1:0]   req_trans_burst_i;
  logic [NR-1:0]           req_tx_valid_i, req_tx_ready_o;
  logic [NR-1:0][15:0]     req_tx_data_i;
  logic [NR-1:0][1:0]      req_tx_strb_i;
  logic [NR-1:0]           req_rx_valid_o, req_rx_ready_i;
  logic [NR-1:0][15:0]     req_rx_data_o;
  logic                    phy_trans_valid_o, phy_trans_ready_i;
  logic [31:0]             phy_trans_address_o;
  logic [NCS-1:0]          phy_trans_cs_o;
  logic                    phy_trans_write_o;
  logic [BW-1:0]           phy_trans_burst_o;
  logic                    phy_tx_valid_o, phy_tx_ready_i;
  logic [15:0]             phy_tx_data_o;
  logic [1:0]              phy_tx_strb_o;
  logic                    phy_rx_valid_i, phy_rx_ready_o;
  logic [15:0]             phy_rx_data_i;
  logic [NR-1:0]           grant_o;
  logic                    busy_o;

  hyperbus_trans_arbiter #(.NR_REQ(NR), .BURST_WIDTH(BW), .NR_CS(NCS)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_trans_valid_i(req_trans_valid_i), .req_trans_ready_o(req_trans_ready_o),
    .req_trans_address_i(req_trans_address_i), .req_trans_cs_i(req_trans_cs_i),
    .req_trans_write_i(req_trans_write_i), .req_trans_burst_i(req_trans_burst_i),
    .req_tx_valid_i(req_tx_valid_i), .req_tx_ready_o(req_tx_ready_o),
    .req_tx_data_i(req_tx_data_i), .req_tx_strb_i(req_tx_strb_i),
    .req_rx_valid_o(req_rx_valid_o), .req_rx_ready_i(req_rx_ready_i),
    .req_rx_data_o(req_rx_data_o),
    .phy_trans_valid_o(phy_trans_valid_o), .phy_trans_ready_i(phy_trans_ready_i),
    .phy_trans_address_o(phy_trans_address_o), .phy_trans_cs_o(phy_trans_cs_o),
    .phy_trans_write_o(phy_trans_write_o), .phy_trans_burst_o(phy_trans_burst_o),
    .phy_tx_valid_o(phy_tx_valid_o), .phy_tx_ready_i(phy_tx_ready_i),
    .phy_tx_data_o(phy_tx_data_o), .phy_tx_strb_o(phy_tx_strb_o),
    .phy_rx_valid_i(phy_rx_valid_i), .phy_rx_ready_o(phy_rx_ready_o),
    .phy_rx_data_i(phy_rx_data_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [1:0]  cs;
    logic        w;
    logic [11:0] b;
  } trans_t;

  typedef struct {
    int          r;
    logic [15:0] d;
  } rx_t;

  trans_t      q_trans[$];
  int          q_ack[$];
  logic [17:0] q_tx[$];
  rx_t         q_rx[$];

  int n_checks = 0;
  int n_errors = 0;
  int tx_cnt[NR];
  int exp_tx_next[NR];
  int rx_cnt;
  int stall_cnt;
  logic tx_toggle, rx_toggle;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(string name, logic [63:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: unexpected event, got %0h expected none", name, act);
  endtask

  function automatic logic [1:0] strb_of(int r);
    return (r == 0) ? 2'b11 : 2'b10;
  endfunction

  // Monitor: compares every DUT-presented handshake against the scoreboard.
  initial begin
    trans_t e;
    rx_t    x;
    logic [17:0] t;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (phy_trans_valid_o && phy_trans_ready_i) begin
          if (q_trans.size() == 0) unexpected("phy_trans", 64'(phy_trans_address_o));
          else begin
            e = q_trans.pop_front();
            check("trans_addr",  64'(phy_trans_address_o), 64'(e.a));
            check("trans_cs",    64'(phy_trans_cs_o), 64'(e.cs));
            check("trans_write", 64'(phy_trans_write_o), 64'(e.w));
            check("trans_burst", 64'(phy_trans_burst_o), 64'(e.b));
            check("trans_grant", 64'(grant_o), 64'(1) << e.r);
          end
        end
        if (|req_trans_ready_o) begin
          if (q_ack.size() == 0) unexpected("trans_ack", 64'(req_trans_ready_o));
          else check("trans_ack", 64'(req_trans_ready_o), 64'(1) << q_ack.pop_front());
        end
        if (phy_tx_valid_o && phy_tx_ready_i) begin
          if (q_tx.size() == 0) unexpected("tx_beat", 64'(phy_tx_data_o));
          else begin
            t = q_tx.pop_front();
            check("tx_beat", 64'({phy_tx_strb_o, phy_tx_data_o}), 64'(t));
          end
        end
        for (int r = 0; r < NR; r++) begin
          if (req_rx_valid_o[r] && req_rx_ready_i[r]) begin
            if (q_rx.size() == 0) unexpected("rx_beat", 64'(req_rx_data_o[r]));
            else begin
              x = q_rx.pop_front();
              check("rx_requester", 64'(r), 64'(x.r));
              check("rx_beat", 64'(req_rx_data_o[r]), 64'(x.d));
            end
          end
        end
      end
    end
  end

  // One clock of requester/PHY behaviour; returns just after the rising edge.
  task automatic tick();
    logic [NR-1:0] ack, txhs;
    logic          rxhs;
    @(negedge clk);
    ack  = req_trans_ready_o;
    txhs = req_tx_valid_i & req_tx_ready_o;
    rxhs = phy_rx_valid_i & phy_rx_ready_o;
    @(posedge clk);
    #1;
    for (int r = 0; r < NR; r++) begin
      if (ack[r]) req_trans_valid_i[r] = 1'b0;
      if (txhs[r]) begin
        tx_cnt[r]++;
        req_tx_data_i[r] = 16'(r * 256 + tx_cnt[r]);
      end
    end
    if (rxhs) rx_cnt++;
    phy_rx_data_i = 16'hC000 + 16'(rx_cnt);
    if (tx_toggle) phy_tx_ready_i = !phy_tx_ready_i;
    if (rx_toggle) phy_rx_valid_i = !phy_rx_valid_i;
    if (stall_cnt > 0) begin
      stall_cnt--;
      req_rx_ready_i = '0;
    end else begin
      req_rx_ready_i = '1;
    end
  endtask

  task automatic post(int r, logic [31:0] a, logic [1:0] cs, logic w, logic [11:0] b);
    trans_t e;
    req_trans_address_i[r] = a;
    req_trans_cs_i[r]      = cs;
    req_trans_write_i[r]   = w;
    req_trans_burst_i[r]   = b;
    req_trans_valid_i[r]   = 1'b1;
    q_ack.push_back(r);
    if (b != 0) begin
      e.r = r; e.a = a; e.cs = cs; e.w = w; e.b = b;
      q_trans.push_back(e);
    end
  endtask

  task automatic push_tx(int r, int n);
    for (int k = 0; k < n; k++) begin
      q_tx.push_back({strb_of(r), 16'(r * 256 + exp_tx_next[r])});
      exp_tx_next[r]++;
    end
  endtask

  task automatic wait_done(string name, int bound);
    for (int n = 0; n < bound; n++) begin
      if (!busy_o && q_trans.size() == 0 && q_ack.size() == 0 &&
          q_tx.size() == 0 && q_rx.size() == 0) break;
      tick();
    end
    check({name, "_idle"}, 64'(busy_o), 64'(0));
    check({name, "_pending"}, 64'(q_trans.size() + q_ack.size() + q_tx.size() + q_rx.size()), 64'(0));
  endtask

  task automatic check_reset_outputs(string name);
    check({name, "_busy"},      64'(busy_o), 64'(0));
    check({name, "_grant"},     64'(grant_o), 64'(0));
    check({name, "_trans_vld"}, 64'(phy_trans_valid_o), 64'(0));
    check({name, "_trans_rdy"}, 64'(req_trans_ready_o), 64'(0));
    check({name, "_tx_vld"},    64'(phy_tx_valid_o), 64'(0));
    check({name, "_tx_rdy"},    64'(req_tx_ready_o), 64'(0));
    check({name, "_rx_vld"},    64'(req_rx_valid_o), 64'(0));
    check({name, "_rx_rdy"},    64'(phy_rx_ready_o), 64'(1));
    check({name, "_addr"},      64'(phy_trans_address_o), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    req_trans_valid_i = '0; req_trans_address_i = '0; req_trans_cs_i = '0;
    req_trans_write_i = '0; req_trans_burst_i = '0;
    req_tx_valid_i = '1;
    for (int r = 0; r < NR; r++) begin
      tx_cnt[r] = 0;
      exp_tx_next[r] = 0;
      req_tx_data_i[r] = 16'(r * 256);
      req_tx_strb_i[r] = strb_of(r);
    end
    req_rx_ready_i = '1;
    phy_trans_ready_i = 1'b1;
    phy_tx_ready_i = 1'b0;
    phy_rx_valid_i = 1'b0;
    rx_cnt = 0;
    phy_rx_data_i = 16'hC000;
    stall_cnt = 0;
    tx_toggle = 1'b0;
    rx_toggle = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Two simultaneous writes, burst 4: requester 0 first, then 1.
    tx_toggle = 1'b1;
    post(0, 32'h1000_0000, 2'b01, 1'b1, 12'd4);
    post(1, 32'h2000_0040, 2'b10, 1'b1, 12'd4);
    push_tx(0, 4);
    push_tx(1, 4);
    tick();
    check("rr_first_grant", 64'(grant_o), 64'(2'b01));
    for (int n = 0; n < 40; n++) begin
      if (grant_o == 2'b10) break;
      tick();
    end
    check("rr_second_grant", 64'(grant_o), 64'(2'b10));
    check("rr_first_beats_done", 64'(q_tx.size()), 64'(4));
    wait_done("rr", 60);

    // Read of 3 beats with toggling PHY valid and a 2-cycle requester stall.
    tx_toggle = 1'b0;
    phy_tx_ready_i = 1'b1;
    rx_cnt = 0;
    phy_rx_data_i = 16'hC000;
    post(0, 32'h0000_8000, 2'b01, 1'b0, 12'd3);
    for (int k = 0; k < 3; k++) q_rx.push_back('{r: 0, d: 16'hC000 + 16'(k)});
    tick();
    tick();
    check("rd_in_data_busy", 64'(busy_o), 64'(1));
    req_rx_ready_i = '0;
    stall_cnt = 1;
    rx_toggle = 1'b1;
    phy_rx_valid_i = 1'b1;
    for (int n = 0; n < 30; n++) begin
      if (rx_cnt == 3) break;
      tick();
    end
    rx_toggle = 1'b0;
    phy_rx_valid_i = 1'b0;
    check("rd_beats", 64'(rx_cnt), 64'(3));
    check("rd_done_busy", 64'(busy_o), 64'(1));
    check("rd_done_rx_vld", 64'(req_rx_valid_o), 64'(0));
    tick();
    check("rd_after_done_busy", 64'(busy_o), 64'(0));
    wait_done("rd", 10);

    // Zero-length burst: ack only, PHY never sees a transaction.
    post(1, 32'h3000_0000, 2'b10, 1'b1, 12'd0);
    tick();
    check("b0_c1_busy", 64'(busy_o), 64'(1));
    check("b0_c1_trans_vld", 64'(phy_trans_valid_o), 64'(0));
    tick();
    check("b0_c2_busy", 64'(busy_o), 64'(1));
    check("b0_c2_trans_vld", 64'(phy_trans_valid_o), 64'(0));
    tick();
    check("b0_c3_busy", 64'(busy_o), 64'(0));
    wait_done("b0", 5);

    // PHY stalls the transaction; fields must hold even if the request changes.
    phy_trans_ready_i = 1'b0;
    post(0, 32'h4000_1234, 2'b01, 1'b1, 12'd2);
    push_tx(0, 2);
    for (int n = 0; n < 6; n++) begin
      tick();
      req_trans_valid_i[0] = 1'b0;
      req_trans_address_i[0] = 32'hDEAD_BEEF;
      req_trans_burst_i[0] = 12'd7;
      check("stall_trans_vld", 64'(phy_trans_valid_o), 64'(1));
      check("stall_addr",  64'(phy_trans_address_o), 64'(32'h4000_1234));
      check("stall_cs",    64'(phy_trans_cs_o), 64'(2'b01));
      check("stall_write", 64'(phy_trans_write_o), 64'(1));
      check("stall_burst", 64'(phy_trans_burst_o), 64'(2));
      check("stall_ack",   64'(req_trans_ready_o), 64'(0));
    end
    phy_trans_ready_i = 1'b1;
    wait_done("stall", 20);

    // Reset in the middle of an 8-beat write, after its second beat.
    post(1, 32'h5000_0000, 2'b10, 1'b1, 12'd8);
    push_tx(1, 2);
    for (int n = 0; n < 30; n++) begin
      if (tx_cnt[1] == exp_tx_next[1]) break;
      tick();
    end
    check("mid_rst_beats", 64'(tx_cnt[1]), 64'(exp_tx_next[1]));
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    tick();
    check_reset_outputs("mid_rst_held");
    rst = 1'b0;
    check("mid_rst_sb_empty", 64'(q_trans.size() + q_ack.size() + q_tx.size()), 64'(0));

    // After reset, arbitration restarts at requester 0.
    post(0, 32'h6000_0000, 2'b01, 1'b1, 12'd1);
    post(1, 32'h7000_0000, 2'b10, 1'b1, 12'd1);
    push_tx(0, 1);
    push_tx(1, 1);
    tick();
    check("post_rst_grant", 64'(grant_o), 64'(2'b01));
    wait_done("post_rst", 40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
